// File: rtl/rand_arbiter.sv
// Round-robin arbiter sharing one external 16-bit LFSR between several random-number consumers.
// Warms the LFSR off its seed after reset, then grants one requester per cycle and advances the LFSR on each grant.

module rand_arbiter_lane (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic win_i,
  output logic elig_o,
  output logic ack_o
);
  logic ack_d, ack_q;

  // A request still high during its own ack cycle must not be served twice.
  assign elig_o = req_i & ~ack_q;
  assign ack_o  = ack_q;

  always_comb begin
    ack_d = win_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ack_q <= 1'b0;
    else       ack_q <= ack_d;
  end
endmodule

module rand_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WARMUP  = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               pause_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] ack_o,
  output logic [15:0]        data_o,
  output logic               ready_o,
  output logic               lfsr_next_o,
  input  logic [15:0]        lfsr_rand_i
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    WARM  = 1'b0,
    SERVE = 1'b1
  } state_e;

  localparam state_e     RST_STATE = (WARMUP == 0) ? SERVE : WARM;
  localparam logic [7:0] WARM_LAST = 8'(WARMUP - 1);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [15:0]        data_q, data_d;
  logic               ready_q, ready_d;

  logic [NUM_REQ-1:0] elig, win_oh, ack;
  logic [PW-1:0]      win_idx, hi_idx, lo_idx;
  logic               hi_found, found, grant, warm_adv;

  // Winner: lowest eligible index at or above ptr, else lowest eligible overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (elig[i] && (PW'(i) >= ptr_q)) begin
        hi_found = 1'b1;
        hi_idx   = PW'(i);
      end
      if (elig[i]) lo_idx = PW'(i);
    end
    found   = |elig;
    win_idx = hi_found ? hi_idx : lo_idx;
  end

  assign warm_adv    = (state_q == WARM) && !pause_i;
  assign grant       = (state_q == SERVE) && !pause_i && found;
  assign lfsr_next_o = warm_adv | grant;

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = grant && (win_idx == PW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    if (warm_adv) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_q == WARM_LAST) state_d = SERVE;
    end
    if (grant) begin
      data_d = lfsr_rand_i;
      ptr_d  = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
    end
    ready_d = (state_d == SERVE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RST_STATE;
      cnt_q   <= 8'd0;
      ptr_q   <= '0;
      data_q  <= 16'h0000;
      ready_q <= (RST_STATE == SERVE);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    rand_arbiter_lane u_lane (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .req_i  (req_i[g]),
      .win_i  (win_oh[g]),
      .elig_o (elig[g]),
      .ack_o  (ack[g])
    );
  end

  assign ack_o   = ack;
  assign data_o  = data_q;
  assign ready_o = ready_q;
endmodule

// File: tb/tb_rand_arbiter.sv
// Randomized scoreboard bench for rand_arbiter with a Galois LFSR (poly 0x002D, seed 1) as the shared source.
module tb_rand_arbiter;
  localparam int          N    = 4;
  localparam int          WU   = 16;
  localparam logic [15:0] POLY = 16'h002D;

  logic          clk;
  logic          rst_i, pause_i;
  logic [N-1:0]  req_i, ack_o;
  logic [15:0]   data_o, lfsr_q;
  logic          ready_o, lfsr_next_o;
  logic [2:0]    req1, ack1;
  logic [15:0]   data1;
  logic          ready1, next1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    time          tg;
    logic [N-1:0] ack;
    logic [15:0]  data;
  } exp_t;
  exp_t sb[$];

  rand_arbiter #(.NUM_REQ(N), .WARMUP(WU)) dut (
    .clk_i(clk), .rst_i(rst_i), .pause_i(pause_i), .req_i(req_i), .ack_o(ack_o),
    .data_o(data_o), .ready_o(ready_o), .lfsr_next_o(lfsr_next_o), .lfsr_rand_i(lfsr_q)
  );

  rand_arbiter #(.NUM_REQ(3), .WARMUP(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .pause_i(1'b0), .req_i(req1), .ack_o(ack1),
    .data_o(data1), .ready_o(ready1), .lfsr_next_o(next1), .lfsr_rand_i(16'hBEEF)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], 1'b0} ^ (v[15] ? POLY : 16'h0000);
  endfunction

  always_ff @(posedge clk) begin
    if (rst_i)            lfsr_q <= 16'h0001;
    else if (lfsr_next_o) lfsr_q <= lfsr_step(lfsr_q);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle from the sampled inputs.
  logic         m_warm = 1'b1;
  int           m_cnt  = 0;
  int           m_ptr  = 0;
  logic [N-1:0] m_ack  = '0;
  logic [15:0]  m_data = 16'h0000;
  logic [15:0]  m_lfsr = 16'h0001;

  initial begin
    logic [N-1:0] elig, nack;
    logic         exp_next;
    int           w, idx;
    exp_t         e;
    forever begin
      @(negedge clk);
      chk("ready", 32'(ready_o), 32'(!m_warm));
      chk("data_hold", 32'(data_o), 32'(m_data));
      if (rst_i) begin
        m_warm = (WU != 0);
        m_cnt  = 0;
        m_ptr  = 0;
        m_ack  = '0;
        m_data = 16'h0000;
        m_lfsr = 16'h0001;
      end else begin
        exp_next = 1'b0;
        nack     = '0;
        if (m_warm) begin
          if (!pause_i) begin
            exp_next = 1'b1;
            m_cnt++;
            if (m_cnt == WU) m_warm = 1'b0;
          end
        end else if (!pause_i) begin
          elig = req_i & ~m_ack;
          w    = -1;
          for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && ((elig >> idx) & N'(1)) != '0) w = idx;
          end
          if (w >= 0) begin
            exp_next = 1'b1;
            nack     = N'(1) << w;
            e.tg     = $time;
            e.ack    = nack;
            e.data   = m_lfsr;
            sb.push_back(e);
            m_data   = m_lfsr;
            m_ptr    = (w + 1) % N;
          end
        end
        chk("lfsr_next", 32'(lfsr_next_o), 32'(exp_next));
        if (exp_next) m_lfsr = lfsr_step(m_lfsr);
        m_ack = nack;
      end
    end
  end

  // Monitor: every ack the DUT presents must match the oldest expected grant, one cycle after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (ack_o !== '0) begin
        if (sb.size() == 0) chk("spurious_ack", 32'(ack_o), 32'd0);
        else begin
          e = sb.pop_front();
          chk("sb_ack", 32'(ack_o), 32'(e.ack));
          chk("sb_data", 32'(data_o), 32'(e.data));
          chk("sb_latency", 32'($time - e.tg), 32'd6);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ready_o !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk(nm, 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic [15:0] vals[8];
    logic [N-1:0] keep;
    logic        prev1;
    int          dups, nacks;

    rst_i = 1'b1; pause_i = 1'b0; req_i = '0; req1 = '0;
    repeat (3) step();
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("wu0_rst_ready", 32'(ready1), 32'd1);

    rst_i = 1'b0;
    req1  = 3'b010;
    #2;
    chk("wu0_next", 32'(next1), 32'd1);
    step();
    chk("wu0_ack", 32'(ack1), 32'(3'b010));
    chk("wu0_data", 32'(data1), 32'h0000BEEF);
    req1 = '0;

    wait_ready("warmup_ready");
    chk("warm_lfsr", 32'(lfsr_q), 32'h0000002D);

    req_i = 4'b0100; step();
    chk("single_ack", 32'(ack_o), 32'(4'b0100));
    chk("single_data", 32'(data_o), 32'h0000002D);
    req_i = '0; step();
    req_i = 4'b0100; step();
    chk("second_data", 32'(data_o), 32'h0000005A);
    req_i = 4'b1000; step();
    chk("ptr_setup_ack", 32'(ack_o), 32'(4'b1000));
    req_i = '0; step();

    req_i = '1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_order", 32'(ack_o), 32'(N'(1) << (i % N)));
      vals[i] = data_o;
    end
    req_i = '0;
    dups = 0;
    for (int i = 0; i < 8; i++)
      for (int j = i + 1; j < 8; j++)
        if (vals[i] == vals[j]) dups++;
    chk("rr_distinct", 32'(dups), 32'd0);
    step();

    req_i = 4'b0010; prev1 = 1'b0; nacks = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_back2back", 32'(prev1 & ack_o[1]), 32'd0);
      prev1 = ack_o[1];
      if (ack_o[1]) nacks++;
    end
    req_i = '0;
    chk("alt_count", 32'(nacks), 32'd5);
    step();

    for (int i = 0; i < 400; i++) begin
      keep    = N'($urandom);
      req_i   = (req_i & ~(ack_o & ~keep)) | (N'($urandom) & N'($urandom));
      pause_i = ($urandom_range(0, 9) == 0);
      step();
    end
    pause_i = 1'b0; req_i = '0;
    repeat (3) step();

    rst_i = 1'b1; step();
    rst_i = 1'b0;
    repeat (5) step();
    pause_i = 1'b1;
    repeat (10) step();
    pause_i = 1'b0;
    wait_ready("pause_warm_ready");
    chk("pause_warm_lfsr", 32'(lfsr_q), 32'h0000002D);

    req_i = 4'b0001; rst_i = 1'b1;
    step();
    chk("midrst_ack", 32'(ack_o), 32'd0);
    chk("midrst_data", 32'(data_o), 32'd0);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    rst_i = 1'b0; req_i = '0;
    wait_ready("rewarm_ready");
    req_i = 4'b0010; step();
    chk("rewarm_ack", 32'(ack_o), 32'(4'b0010));
    chk("rewarm_data", 32'(data_o), 32'h0000002D);
    req_i = '0;
    repeat (3) step();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
